// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants for the MEM/WB, ID/EX and EX/MEM stages
package pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int CNT_W    = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    function automatic logic [DATA_W-1:0] wb_select(
        input logic              mem_to_reg,
        input logic [DATA_W-1:0] mem_data,
        input logic [DATA_W-1:0] alu_result
    );
        return mem_to_reg ? mem_data : alu_result;
    endfunction

endpackage

// File: rtl/reg_array.sv
// rtl/reg_array.sv - 1-write/3-read register storage with r0 hardwired to zero
module reg_array
    import pipe_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr0_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we_i && (waddr_i != ZERO_REG)) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // r0 is forced on the read side so it reads zero even before the first reset edge
    assign rdata0_o = (raddr0_i == ZERO_REG) ? '0 : mem_q[raddr0_i];
    assign rdata1_o = (raddr1_i == ZERO_REG) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == ZERO_REG) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, bypassed register file reads and retired-write counter
module wb_regfile
    import pipe_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] MemData_i,
    input  logic [ADDR_W-1:0] RegAddr_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic [CNT_W-1:0]  retire_cnt_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic              we;
    logic [DATA_W-1:0] rs1_arr;
    logic [DATA_W-1:0] rs2_arr;
    logic [CNT_W-1:0]  retire_cnt_q;
    logic [CNT_W-1:0]  retire_cnt_d;

    assign WBdata_o = wb_select(MemtoReg_i, MemData_i, ALUResult_i);
    assign we       = rst_n_i & start_i & RegWrite_i & (RegAddr_i != ZERO_REG);

    reg_array u_reg_array (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .we_i     (we),
        .waddr_i  (RegAddr_i),
        .wdata_i  (WBdata_o),
        .raddr0_i (RS1addr_i),
        .raddr1_i (RS2addr_i),
        .raddr2_i (dbg_addr_i),
        .rdata0_o (rs1_arr),
        .rdata1_o (rs2_arr),
        .rdata2_o (dbg_data_o)
    );

    // we already excludes r0, so the bypass can never leak a value onto an address-0 read
    always_comb begin
        RS1data_o = rs1_arr;
        RS2data_o = rs2_arr;
        if (!rst_n_i) begin
            RS1data_o = '0;
            RS2data_o = '0;
        end else begin
            if (we && (RS1addr_i == RegAddr_i)) RS1data_o = WBdata_o;
            if (we && (RS2addr_i == RegAddr_i)) RS2data_o = WBdata_o;
        end
    end

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (we) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed and random stimulus against a reference register-file model
module tb_wb_regfile;

    logic        clk;
    logic        rst_n_i;
    logic        start_i;
    logic        MemtoReg_i;
    logic        RegWrite_i;
    logic [31:0] ALUResult_i;
    logic [31:0] MemData_i;
    logic [4:0]  RegAddr_i;
    logic [4:0]  RS1addr_i;
    logic [4:0]  RS2addr_i;
    logic [31:0] RS1data_o;
    logic [31:0] RS2data_o;
    logic [31:0] WBdata_o;
    logic [31:0] retire_cnt_o;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_data_o;

    wb_regfile dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .MemtoReg_i   (MemtoReg_i),
        .RegWrite_i   (RegWrite_i),
        .ALUResult_i  (ALUResult_i),
        .MemData_i    (MemData_i),
        .RegAddr_i    (RegAddr_i),
        .RS1addr_i    (RS1addr_i),
        .RS2addr_i    (RS2addr_i),
        .RS1data_o    (RS1data_o),
        .RS2data_o    (RS2data_o),
        .WBdata_o     (WBdata_o),
        .retire_cnt_o (retire_cnt_o),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_data_o   (dbg_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] regs [32];
    logic [31:0] cnt_m;
    bit          model_valid;
    int          total;
    int          passed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] port_exp(input logic [4:0] a, input bit rst, input bit wr,
                                             input logic [4:0] wa, input logic [31:0] wb);
        if (!rst)                return 32'h0;
        if (a == 5'd0)           return 32'h0;
        if (wr && a == wa)       return wb;
        return regs[a];
    endfunction

    // Drive one cycle's inputs mid-cycle, check outputs before the edge, then advance the model.
    task automatic cycle(input bit rst, input bit st, input bit rw, input bit mt,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] wa, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] da);
        logic [31:0] wb;
        bit          wr;
        rst_n_i = rst; start_i = st; RegWrite_i = rw; MemtoReg_i = mt;
        ALUResult_i = alu; MemData_i = mem; RegAddr_i = wa;
        RS1addr_i = a1; RS2addr_i = a2; dbg_addr_i = da;
        #2;
        wb = mt ? mem : alu;
        wr = rst && st && rw && (wa != 5'd0);
        chk("wbdata", WBdata_o, wb);
        chk("rs1", RS1data_o, port_exp(a1, rst, wr, wa, wb));
        chk("rs2", RS2data_o, port_exp(a2, rst, wr, wa, wb));
        if (model_valid) begin
            chk("dbg", dbg_data_o, regs[da]);
            chk("retire_cnt", retire_cnt_o, cnt_m);
        end
        @(posedge clk);
        if (!rst) begin
            foreach (regs[i]) regs[i] = 32'h0;
            cnt_m = 32'h0;
            model_valid = 1'b1;
        end else if (wr) begin
            regs[wa] = wb;
            cnt_m = cnt_m + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        passed = 0;
        model_valid = 1'b0;
        cnt_m = 32'h0;
        foreach (regs[i]) regs[i] = 32'h0;
        rst_n_i = 1'b0; start_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0;
        ALUResult_i = '0; MemData_i = '0; RegAddr_i = '0;
        RS1addr_i = '0; RS2addr_i = '0; dbg_addr_i = '0;
        @(negedge clk);

        // Reset held for two edges with a write pending to r5
        cycle(0, 1, 1, 0, 32'hDEAD, 32'h0, 5'd5, 5'd5, 5'd5, 5'd5);
        cycle(0, 1, 1, 0, 32'hDEAD, 32'h0, 5'd5, 5'd5, 5'd0, 5'd5);
        for (int i = 0; i < 32; i++) begin
            cycle(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'(i));
        end

        // Write with same-cycle bypass on both ports, then array visibility
        cycle(1, 1, 1, 0, 32'h12345678, 32'h5A5A5A5A, 5'd7, 5'd7, 5'd7, 5'd7);
        cycle(1, 1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7, 5'd7);
        chk("cnt_after_r7", retire_cnt_o, 32'd1);

        // Load select aimed at r0
        cycle(1, 1, 1, 1, 32'h11111111, 32'hCAFEF00D, 5'd0, 5'd0, 5'd0, 5'd0);
        cycle(1, 1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 5'd0);

        // start_i gating: prime r3 then attempt a gated write
        cycle(1, 1, 1, 1, 32'h0, 32'h00001234, 5'd3, 5'd1, 5'd2, 5'd3);
        cycle(1, 0, 1, 0, 32'h0000FFFF, 32'h0, 5'd3, 5'd3, 5'd3, 5'd3);
        cycle(1, 1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0, 5'd3);

        // Reset landing on a valid write
        cycle(1, 1, 1, 0, 32'hAA, 32'h0, 5'd9, 5'd9, 5'd1, 5'd9);
        cycle(0, 1, 1, 0, 32'hBB, 32'h0, 5'd9, 5'd9, 5'd9, 5'd9);
        cycle(1, 1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9, 5'd9);

        // Back-to-back writes to one register
        cycle(1, 1, 1, 0, 32'h100, 32'h0, 5'd12, 5'd12, 5'd12, 5'd12);
        cycle(1, 1, 1, 1, 32'h0, 32'h200, 5'd12, 5'd12, 5'd12, 5'd12);
        cycle(1, 1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd12, 5'd12, 5'd12);

        // Counter wrap from all-ones
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        cnt_m = 32'hFFFFFFFF;
        cycle(1, 1, 1, 0, 32'h77, 32'h0, 5'd1, 5'd1, 5'd2, 5'd1);
        cycle(1, 1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd1, 5'd1);
        chk("cnt_wrap", retire_cnt_o, 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom),
                  $urandom, $urandom,
                  5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
